// File: rtl/detect_sched.sv
// Round-robin scheduler that serialises one requester's word MSB first through
// an overlapping 1101 Mealy detector and reports the match count.
module detect_sched #(
  parameter int N_REQ = 4,
  parameter int W     = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*W-1:0]         data,
  output logic [N_REQ-1:0]           gnt,
  output logic                       busy,
  output logic                       bit_out,
  output logic                       y_out,
  output logic                       done,
  output logic [$clog2(N_REQ)-1:0]   done_id,
  output logic [$clog2(W+1)-1:0]     match_cnt
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(W+1);
  localparam int BC_W  = $clog2(W);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_REPORT} state_t;
  typedef enum logic [1:0] {D0, D1, D2, D3} det_t;

  state_t            r_state, w_next;
  det_t              r_det, w_det_next;
  logic [ID_W-1:0]   r_last_id, w_winner;
  logic              w_any_req;
  logic [W-1:0]      r_shreg;
  logic [BC_W-1:0]   r_bit_cnt;
  logic [CNT_W-1:0]  r_match_cnt;
  logic              w_last_bit, w_bit, w_match;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  assign w_last_bit = (r_bit_cnt == BC_W'(W-1));

  // NOTE: each combinational output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:   w_next = w_any_req ? S_LOAD : S_IDLE;
      S_LOAD:   w_next = S_SHIFT;
      S_SHIFT:  w_next = w_last_bit ? S_REPORT : S_SHIFT;
      S_REPORT: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Scan from the farthest offset down so the nearest set request after
  // last_id is the one left standing.
  always_comb begin
    int w_idx;
    w_idx     = 0;
    w_winner  = r_last_id;
    w_any_req = |req;
    for (int off = N_REQ; off >= 1; off--) begin
      w_idx = (int'(r_last_id) + off) % N_REQ;
      if (req[w_idx]) w_winner = ID_W'(w_idx);
    end
  end

  assign w_bit   = r_shreg[W-1];
  assign w_match = (r_det == D3) && w_bit;

  always_comb begin
    w_det_next = D0;
    case (r_det)
      D0:      w_det_next = w_bit ? D1 : D0;
      D1:      w_det_next = w_bit ? D2 : D0;
      D2:      w_det_next = w_bit ? D2 : D3;
      D3:      w_det_next = w_bit ? D1 : D0;
      default: w_det_next = D0;
    endcase
  end

  // last_id doubles as the id of the word in flight from the IDLE decision on.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_id   <= ID_W'(N_REQ-1);
      r_shreg     <= '0;
      r_bit_cnt   <= '0;
      r_match_cnt <= '0;
      r_det       <= D0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) r_last_id <= w_winner;
        end
        S_LOAD: begin
          r_shreg     <= data[r_last_id*W +: W];
          r_bit_cnt   <= '0;
          r_match_cnt <= '0;
          r_det       <= D0;
        end
        S_SHIFT: begin
          r_shreg     <= {r_shreg[W-2:0], 1'b0};
          r_bit_cnt   <= r_bit_cnt + BC_W'(1);
          r_match_cnt <= r_match_cnt + CNT_W'(w_match);
          r_det       <= w_det_next;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    gnt       = '0;
    busy      = 1'b0;
    bit_out   = 1'b0;
    y_out     = 1'b0;
    done      = 1'b0;
    done_id   = '0;
    match_cnt = '0;
    case (r_state)
      S_LOAD: begin
        gnt[r_last_id] = 1'b1;
        busy           = 1'b1;
      end
      S_SHIFT: begin
        busy    = 1'b1;
        bit_out = w_bit;
        y_out   = w_match;
      end
      S_REPORT: begin
        busy      = 1'b1;
        done      = 1'b1;
        done_id   = r_last_id;
        match_cnt = r_match_cnt;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_detect_sched.sv
// Directed and random transactions for detect_sched, checked cycle by cycle
// against a window-scan model of the 1101 detector and a round-robin picker.
module tb_detect_sched;

  localparam int N_REQ = 4;
  localparam int W     = 8;

  logic               clk = 1'b0;
  logic               reset;
  logic [N_REQ-1:0]   req;
  logic [N_REQ*W-1:0] data;
  logic [N_REQ-1:0]   gnt;
  logic               busy, bit_out, y_out, done;
  logic [1:0]         done_id;
  logic [3:0]         match_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int model_last;

  detect_sched #(.N_REQ(N_REQ), .W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .data      (data),
    .gnt       (gnt),
    .busy      (busy),
    .bit_out   (bit_out),
    .y_out     (y_out),
    .done      (done),
    .done_id   (done_id),
    .match_cnt (match_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // First set request at or after (last+1) mod N_REQ.
  function automatic int rr_pick(input logic [N_REQ-1:0] r, input int last);
    for (int off = 1; off <= N_REQ; off++) begin
      if (r[(last + off) % N_REQ]) return (last + off) % N_REQ;
    end
    return 0;
  endfunction

  // Match on bit j (0-based, MSB first) when the last four bits seen are 1101.
  function automatic logic ref_y(input logic [W-1:0] word, input int j);
    if (j < 3) return 1'b0;
    return word[W+2-j -: 4] == 4'b1101;
  endfunction

  function automatic int ref_count(input logic [W-1:0] word);
    int c = 0;
    for (int j = 0; j < W; j++) c += int'(ref_y(word, j));
    return c;
  endfunction

  function automatic logic [N_REQ*W-1:0] put_lane(input logic [N_REQ*W-1:0] base,
                                                  input int lane, input logic [W-1:0] w);
    logic [N_REQ*W-1:0] b = base;
    b[lane*W +: W] = w;
    return b;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},       gnt,       0);
    check({tag, "_busy"},      busy,      0);
    check({tag, "_bit"},       bit_out,   0);
    check({tag, "_y"},         y_out,     0);
    check({tag, "_done"},      done,      0);
    check({tag, "_done_id"},   done_id,   0);
    check({tag, "_match_cnt"}, match_cnt, 0);
  endtask

  task automatic apply_reset(input int cycles, input logic [N_REQ-1:0] r_release);
    reset = 1'b1;
    repeat (cycles) @(negedge clk);
    check_all_zero("reset");
    req        = r_release;
    reset      = 1'b0;
    model_last = N_REQ - 1;
  endtask

  // Entered and left in an IDLE cycle at the falling edge; the next call's
  // first step must land on LOAD, so back-to-back spacing is one IDLE cycle.
  task automatic do_txn(input logic [N_REQ-1:0] r, input logic [N_REQ*W-1:0] d,
                        input logic [N_REQ-1:0] r_after, input string tag);
    int           win;
    logic [W-1:0] word;
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_idle_done"}, done, 0);
    req  = r;
    data = d;
    win  = rr_pick(r, model_last);
    word = d[win*W +: W];
    @(negedge clk);
    check({tag, "_gnt"},      gnt,  32'(1) << win);
    check({tag, "_load_busy"}, busy, 1);
    req = r_after;
    for (int j = 0; j < W; j++) begin
      @(negedge clk);
      if (j == 0) data = {$urandom};
      check($sformatf("%s_bit%0d", tag, j),  bit_out, word[W-1-j]);
      check($sformatf("%s_y%0d", tag, j),    y_out,   ref_y(word, j));
      check($sformatf("%s_sgnt%0d", tag, j), gnt,     0);
      check($sformatf("%s_sdone%0d", tag, j), done,   0);
      check($sformatf("%s_scnt%0d", tag, j), match_cnt, 0);
    end
    @(negedge clk);
    check({tag, "_done"},      done,      1);
    check({tag, "_done_id"},   done_id,   win);
    check({tag, "_match_cnt"}, match_cnt, ref_count(word));
    check({tag, "_rep_bit"},   bit_out,   0);
    model_last = win;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    req   = '0;
    data  = '0;
    apply_reset(3, '0);
    @(negedge clk);
    check_all_zero("idle");

    do_txn(4'b0001, put_lane({$urandom}, 0, 8'hDB), 4'b0000, "db");
    do_txn(4'b0001, put_lane({$urandom}, 0, 8'h00), 4'b0000, "x00");
    do_txn(4'b0001, put_lane({$urandom}, 0, 8'hFF), 4'b0000, "xff");
    do_txn(4'b0001, put_lane({$urandom}, 0, 8'h0D), 4'b0000, "x0d");

    apply_reset(2, 4'b1111);
    for (int i = 0; i < 5; i++)
      do_txn(4'b1111, {$urandom}, 4'b1111, $sformatf("fair%0d", i));

    do_txn(4'b0010, {$urandom}, 4'b0000, "skip_pre");
    do_txn(4'b1010, {$urandom}, 4'b1010, "skip_a");
    do_txn(4'b1010, {$urandom}, 4'b0000, "skip_b");

    // Abort in the third SHIFT cycle.
    req  = 4'b0001;
    data = put_lane({$urandom}, 0, 8'hB6);
    @(negedge clk);
    check("abort_gnt", gnt, 1);
    req = '0;
    repeat (3) @(negedge clk);
    check("abort_busy", busy, 1);
    check("abort_done", done, 0);
    apply_reset(1, 4'b0110);
    do_txn(4'b0110, {$urandom}, 4'b0110, "post_abort");

    do_txn(4'b0100, {$urandom}, 4'b0000, "withdraw");

    for (int i = 0; i < 20; i++)
      do_txn(4'($urandom_range(1, 15)), {$urandom}, 4'($urandom_range(0, 15)),
             $sformatf("rnd%0d", i));

    req = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("tail_busy%0d", i), busy, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
